// File: rtl/detect_arbiter_if.sv
// Request/grant/result bundle between the serial-pattern clients and detect_arbiter.
// The master side drives requests and words; the slave side returns grant and results.
interface detect_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) ();
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic                      done;
  logic [ID_W-1:0]           done_id;
  logic [CNT_W-1:0]          match_cnt;
  logic                      det_o;

  modport master (
    output req,
    output req_data,
    input  grant,
    input  busy,
    input  done,
    input  done_id,
    input  match_cnt,
    input  det_o
  );

  modport slave (
    input  req,
    input  req_data,
    output grant,
    output busy,
    output done,
    output done_id,
    output match_cnt,
    output det_o
  );
endinterface

// File: rtl/detect_arbiter.sv
// Round-robin sharing of one overlapping "1101" Moore detector among NUM_REQ requesters.
// Each granted word is shifted MSB-first through the detector and its match count reported.
module detect_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  detect_arbiter_if.slave  bus
);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StReport} state_e;
  typedef enum logic [2:0] {DetS0, DetS1, DetS2, DetS3, DetS4} det_e;

  state_e              st_q, st_d;
  det_e                det_q, det_d, det_nxt;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;

  logic                found;
  logic [ID_W-1:0]     winner;

  function automatic det_e det_step(input det_e s, input logic b);
    det_e n;
    n = DetS0;
    unique case (s)
      DetS0:   n = b ? DetS1 : DetS0;
      DetS1:   n = b ? DetS2 : DetS0;
      DetS2:   n = b ? DetS2 : DetS3;
      DetS3:   n = b ? DetS4 : DetS0;
      DetS4:   n = b ? DetS2 : DetS0;
      default: n = DetS0;
    endcase
    return n;
  endfunction

  // Scan starting just after the last winner so the previous winner ranks last.
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign det_nxt = det_step(det_q, shift_q[DATA_W-1]);

  always_comb begin
    st_d    = st_q;
    det_d   = det_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    grant_d = grant_q;
    unique case (st_q)
      StIdle: begin
        if (found) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_d[i] = (ID_W'(i) == winner);
          end
          shift_d = bus.req_data[32'(winner)*DATA_W +: DATA_W];
          det_d   = DetS0;
          cnt_d   = '0;
          bit_d   = '0;
          ptr_d   = winner;
          id_d    = winner;
          st_d    = StShift;
        end
      end
      StShift: begin
        det_d   = det_nxt;
        shift_d = {shift_q[DATA_W-2:0], 1'b0};
        if (det_nxt == DetS4) begin
          cnt_d = cnt_q + 1'b1;
        end
        bit_d = bit_q + 1'b1;
        if (bit_q == CNT_W'(DATA_W - 1)) begin
          st_d = StReport;
        end
      end
      StReport: begin
        grant_d = '0;
        st_d    = StIdle;
      end
      default: begin
        grant_d = '0;
        st_d    = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= StIdle;
      det_q   <= DetS0;
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      grant_q <= '0;
    end else begin
      st_q    <= st_d;
      det_q   <= det_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      grant_q <= grant_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = (st_q != StIdle);
  assign bus.done      = (st_q == StReport);
  assign bus.done_id   = id_q;
  assign bus.match_cnt = cnt_q;
  assign bus.det_o     = (det_q == DetS4);
endmodule

// File: tb/tb_detect_arbiter.sv
// Directed and randomized jobs for detect_arbiter, checked cycle by cycle against a
// substring-counting / round-robin reference model.
module tb_detect_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  detect_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  detect_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int m_ptr;
  int last_id;
  int last_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int ptr, input logic [NR-1:0] r);
    for (int i = 1; i <= NR; i++) begin
      if (r[(ptr + i) % NR]) return (ptr + i) % NR;
    end
    return -1;
  endfunction

  // True when the k-th bit sent (1-based, MSB first) completes a "1101".
  function automatic bit hit(input logic [DW-1:0] w, input int k);
    logic [3:0] win;
    if (k < 4) return 1'b0;
    win = w[DW-k+3 -: 4];
    return win == 4'b1101;
  endfunction

  // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE.
  task automatic run_job(input logic [NR-1:0] r, input logic [NR*DW-1:0] d, input bit perturb);
    int w;
    int cnt;
    logic [DW-1:0] word;
    w    = pick(m_ptr, r);
    word = d[w*DW +: DW];
    bus.req      = r;
    bus.req_data = d;
    @(negedge clk);
    chk("grant_start", 32'(bus.grant), 32'(1) << w);
    chk("busy_start", 32'(bus.busy), 1);
    chk("cnt_clear", 32'(bus.match_cnt), 0);
    chk("done_start", 32'(bus.done), 0);
    if (perturb) begin
      bus.req_data = ~d;
      bus.req      = '0;
    end
    cnt = 0;
    for (int k = 1; k <= DW; k++) begin
      @(negedge clk);
      if (hit(word, k)) cnt++;
      chk("det_o", 32'(bus.det_o), 32'(hit(word, k)));
      chk("match_cnt", 32'(bus.match_cnt), cnt);
      chk("done", 32'(bus.done), 32'(k == DW));
      chk("grant_hold", 32'(bus.grant), 32'(1) << w);
    end
    chk("done_id", 32'(bus.done_id), w);
    m_ptr    = w;
    last_id  = w;
    last_cnt = cnt;
    @(negedge clk);
    chk("idle_grant", 32'(bus.grant), 0);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_done", 32'(bus.done), 0);
    chk("hold_id", 32'(bus.done_id), last_id);
    chk("hold_cnt", 32'(bus.match_cnt), last_cnt);
  endtask

  initial begin
    logic [NR-1:0] r;
    logic [NR*DW-1:0] d;
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    m_ptr        = NR - 1;
    last_id      = 0;
    last_cnt     = 0;
    #1;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_id", 32'(bus.done_id), 0);
    chk("rst_cnt", 32'(bus.match_cnt), 0);
    chk("rst_det", 32'(bus.det_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a job while det_o is high.
    bus.req      = 4'b0010;
    bus.req_data = {8'h00, 8'h00, 8'b1101_0000, 8'h00};
    @(negedge clk);
    chk("pre_rst_grant", 32'(bus.grant), 32'h2);
    repeat (4) @(negedge clk);
    chk("pre_rst_det", 32'(bus.det_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(bus.grant), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_det", 32'(bus.det_o), 0);
    chk("mid_rst_cnt", 32'(bus.match_cnt), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    bus.req = '0;
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = NR - 1;

    // Round robin with all requesting, straight after reset: 0,1,2,3,0.
    for (int j = 0; j < 5; j++) begin
      run_job(4'b1111, {$urandom, $urandom}, 1'b0);
    end
    bus.req = '0;
    @(negedge clk);

    // Directed words.
    run_job(4'b0001, {24'h0, 8'b1101_1010}, 1'b0);
    run_job(4'b0001, {24'h0, 8'b0110_1101}, 1'b0);
    run_job(4'b0001, {24'h0, 8'hFF}, 1'b0);
    bus.req = '0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_nodone", 32'(bus.done), 0);
      chk("idle_keep_cnt", 32'(bus.match_cnt), last_cnt);
    end

    // Data change and request drop mid-job.
    run_job(4'b0100, {8'h00, 8'b1101_1101, 16'h0}, 1'b1);
    chk("drop_noregrant", 32'(bus.busy), 0);

    // Job A ends in "110", job B opens with 1: no carried match.
    run_job(4'b0001, {24'h0, 8'b0000_0110}, 1'b0);
    run_job(4'b0001, {24'h0, 8'b1000_0000}, 1'b0);

    // Random jobs.
    for (int j = 0; j < 20; j++) begin
      r = NR'($urandom_range(1, (1 << NR) - 1));
      d = {$urandom, $urandom};
      run_job(r, d, 1'($urandom_range(0, 1)));
    end
    bus.req = '0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
